alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational 64-bit `alu` instance between NUM_REQ requesters, for example the integer pipe and a multi-cycle address/CSR helper.
- Each requester has a valid/ready request channel.
- A round-robin arbiter grants one request per cycle.
- The ALU result is captured in a single registered response slot, tagged with the requester ID and an illegal-op flag.
- The response channel is valid/ready with full backpressure.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 64, operand/result width passed to alu
ID_W, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), requester ID width (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant/accept (one-hot or zero)
req_a  input  NUM_REQ*DATA_WIDTH  operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_b  input  NUM_REQ*DATA_WIDTH  operand B, same packing
req_sel  input  NUM_REQ*5  ALU op select, requester i at [i*5 +: 5]
rsp_valid  output  1  response slot holds a result
rsp_ready  input  1  consumer accepts response
rsp_data  output  DATA_WIDTH  registered ALU result
rsp_id  output  ID_W  index of requester that produced rsp_data
rsp_err  output  1  op select was illegal (sel > 5'd14)

Behaviour:
- Reset (async assert, sync deassert internally handled by flops on negedge rst_n):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, rr_ptr=0.
  - req_ready is combinational and is 0 while rsp_valid=0 and no req_valid is high.
- Slot state is implicit:
  - EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
  - slot_free = !rsp_valid | rsp_ready.
- Arbitration (combinational):
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner] = slot_free; all other req_ready bits = 0.
  - req_ready never depends on rsp_data.
- Transfer (req_valid[i] & req_ready[i]) at a clock edge:
  - rsp_data <= alu(req_a[i], req_b[i], req_sel[i]).
  - rsp_id <= i; rsp_err <= (req_sel[i] > 5'd14); rsp_valid <= 1.
  - rr_ptr <= (i == NUM_REQ-1) ? 0 : i+1.
- Illegal sel: the ALU default yields 0. rsp_data=0, rsp_err=1, and the result is still delivered normally.
- No transfer, rsp_valid & rsp_ready: rsp_valid <= 0. rsp_data, rsp_id and rsp_err hold their last values.
- FULL and !rsp_ready: no grant. All outputs hold stable, and rr_ptr holds.
- Simultaneous drain and accept (FULL, rsp_ready=1, new transfer): the slot is overwritten with the new result and rsp_valid stays 1. This gives back-to-back throughput of 1 op/cycle.
- Latency: 1 cycle from accepting edge to rsp_valid=1 with data.
- rr_ptr advances only on a transfer.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Requester contract:
  - Once req_valid[i]=1, it holds req_valid[i]=1 and stable operands/sel until accepted.
  - The bench asserts this contract; the RTL does not check it.
- Reset mid-operation: a pending response is discarded (rsp_valid->0 immediately on rst_n low) and rr_ptr returns to 0. Requests unaccepted at reset are not remembered.
- Width rules:
  - Operands pass unmodified to alu.
  - *W ops sign-extend bit 31 into [63:32] inside alu; no extra extension here.

Decomposition:
- Package alu_pkg:
  - ALU_SEL_W=5.
  - typedef enum logic [4:0] alu_op_e {ADD=0, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, ADDW, SUBW, SLLW, SRLW, SRAW}.
  - ALU_OP_MAX=5'd14.
- The existing alu is instantiated once, with its sel port driven from the muxed winner.
- One sub-module, rr_arbiter (params N; in: req[N], ptr[ID_W], en; out: gnt[N] one-hot, gnt_idx[ID_W]), holds the combinational priority rotation.
- rr_ptr and the response slot stay in alu_arbiter.

Test Plan:
1. Single op: req0 ADD a=5, b=7, rsp_ready=1.
   -> req_ready[0]=1 same cycle; next cycle rsp_valid=1, rsp_data=12, rsp_id=0, rsp_err=0.
2. Contention: req0 and req1 both valid with rsp_ready=1 for 4 cycles, each re-presenting after acceptance.
   -> grant order 0,1,0,1; rsp_id sequence 0,1,0,1 on consecutive cycles.
3. Backpressure: complete one op, then hold rsp_ready=0 for 3 cycles while req1 is valid.
   -> req_ready=0; rsp_data/rsp_id stable.
   -> on rsp_ready=1: same-cycle accept of req1; its result appears the next cycle.
4. Word ops: SUBW a=0, b=1 -> rsp_data=64'hFFFF_FFFF_FFFF_FFFF.
   SRLW a=64'h0000_0000_8000_0000, b=0 -> 64'hFFFF_FFFF_8000_0000.
5. Illegal sel: req1 sel=5'b11111, a=3, b=4 -> rsp_data=0, rsp_err=1, rsp_id=1, handshake completes normally.
6. Reset mid-op: rsp_valid=1 with rr_ptr=1, then pulse rst_n low asynchronously between edges.
   -> rsp_valid=0 immediately; after release, both requesters valid -> req0 granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-select encoding and the highest legal op code.
package alu_pkg;

  localparam int ALU_SEL_W = 5;

  typedef enum logic [ALU_SEL_W-1:0] {
    ADD  = 5'd0,
    SUB  = 5'd1,
    AND  = 5'd2,
    OR   = 5'd3,
    XOR  = 5'd4,
    SLT  = 5'd5,
    SLTU = 5'd6,
    SLL  = 5'd7,
    SRL  = 5'd8,
    SRA  = 5'd9,
    ADDW = 5'd10,
    SUBW = 5'd11,
    SLLW = 5'd12,
    SRLW = 5'd13,
    SRAW = 5'd14
  } alu_op_e;

  localparam logic [ALU_SEL_W-1:0] ALU_OP_MAX = 5'd14;

  function automatic logic is_illegal_op(input logic [ALU_SEL_W-1:0] sel);
    return sel > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; *W ops compute on [31:0] and sign-extend bit 31.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [ALU_SEL_W-1:0]  sel,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt;
  logic [4:0]     shamt_w;
  logic [31:0]    word;
  logic           is_word;

  always_comb begin
    shamt   = b[SHW-1:0];
    shamt_w = b[4:0];
    word    = '0;
    is_word = 1'b0;
    result  = '0;
    case (sel)
      ADD:  result = a + b;
      SUB:  result = a - b;
      AND:  result = a & b;
      OR:   result = a | b;
      XOR:  result = a ^ b;
      SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      SLL:  result = a << shamt;
      SRL:  result = a >> shamt;
      SRA:  result = DATA_WIDTH'($signed(a) >>> shamt);
      ADDW: begin is_word = 1'b1; word = a[31:0] + b[31:0]; end
      SUBW: begin is_word = 1'b1; word = a[31:0] - b[31:0]; end
      SLLW: begin is_word = 1'b1; word = a[31:0] << shamt_w; end
      SRLW: begin is_word = 1'b1; word = a[31:0] >> shamt_w; end
      SRAW: begin is_word = 1'b1; word = 32'($signed(a[31:0]) >>> shamt_w); end
      default: result = '0;
    endcase
    if (is_word) result = {{(DATA_WIDTH-32){word[31]}}, word};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
    if (found && en) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters with a single registered response slot.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int DATA_WIDTH = 64,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*ALU_SEL_W-1:0]    req_sel,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [ID_W-1:0]                 rsp_id,
  output logic                            rsp_err
);

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [ID_W-1:0]       rsp_id_q,    rsp_id_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [ID_W-1:0]       rr_ptr_q,    rr_ptr_d;

  logic                  slot_free;
  logic                  xfer;
  logic [ID_W-1:0]       gnt_idx;
  logic [DATA_WIDTH-1:0] op_a, op_b, alu_res;
  logic [ALU_SEL_W-1:0]  op_sel;

  // The slot can take a new result when empty or when it drains this cycle.
  assign slot_free = !rsp_valid_q || rsp_ready;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (slot_free),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  assign xfer   = |req_ready;
  assign op_a   = req_a[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign op_b   = req_b[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign op_sel = req_sel[int'(gnt_idx)*ALU_SEL_W +: ALU_SEL_W];

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .sel    (op_sel),
    .result (alu_res)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = alu_res;
      rsp_id_d    = gnt_idx;
      rsp_err_d   = is_illegal_op(op_sel);
      rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters and hand-computed results.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [9:0]   req_sel;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [63:0]  rsp_data;
  logic         rsp_id;
  logic         rsp_err;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.NUM_REQ(2), .DATA_WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] s);
    req_valid[i]       = v;
    req_a[i*64 +: 64]  = a;
    req_b[i*64 +: 64]  = b;
    req_sel[i*5 +: 5]  = s;
  endtask

  task automatic check_rsp(input string tag, input logic [63:0] data,
                           input logic id, input logic err);
    check({tag, "_valid"}, {63'd0, rsp_valid}, 64'd1);
    check({tag, "_data"},  rsp_data, data);
    check({tag, "_id"},    {63'd0, rsp_id}, {63'd0, id});
    check({tag, "_err"},   {63'd0, rsp_err}, {63'd0, err});
  endtask

  // Requester contract: a request not accepted must be held, operands unchanged.
  logic [1:0]  pend;
  logic [63:0] pa [2];
  logic [63:0] pb [2];
  logic [4:0]  ps [2];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pend[i])
          check($sformatf("hold_req%0d", i),
                {63'd0, (req_valid[i] && req_a[i*64 +: 64] == pa[i] &&
                         req_b[i*64 +: 64] == pb[i] && req_sel[i*5 +: 5] == ps[i])},
                64'd1);
        pend[i] <= req_valid[i] && !req_ready[i];
        pa[i]   <= req_a[i*64 +: 64];
        pb[i]   <= req_b[i*64 +: 64];
        ps[i]   <= req_sel[i*5 +: 5];
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    #12;
    check("rst_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_data",  rsp_data, 64'd0);
    check("rst_id",    {63'd0, rsp_id}, 64'd0);
    check("rst_err",   {63'd0, rsp_err}, 64'd0);
    check("rst_ready", {62'd0, req_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single ADD from requester 0
    set_req(0, 1'b1, 64'd5, 64'd7, ADD);
    rsp_ready = 1'b1;
    #1 check("t1_ready", {62'd0, req_ready}, 64'd1);
    tick();
    check_rsp("t1", 64'd12, 1'b0, 1'b0);
    set_req(0, 1'b0, 64'd0, 64'd0, ADD);
    tick();
    check("t1_drain", {63'd0, rsp_valid}, 64'd0);
    check("t1_hold",  rsp_data, 64'd12);

    // illegal op from requester 1
    set_req(1, 1'b1, 64'd3, 64'd4, 5'b11111);
    #1 check("t5_ready", {62'd0, req_ready}, 64'd2);
    tick();
    check_rsp("t5", 64'd0, 1'b1, 1'b1);
    set_req(1, 1'b0, 64'd0, 64'd0, ADD);
    tick();
    check("t5_drain", {63'd0, rsp_valid}, 64'd0);

    // contention: grants alternate 0,1,0,1 with back-to-back throughput
    set_req(0, 1'b1, 64'd1,  64'd1, ADD);
    set_req(1, 1'b1, 64'd10, 64'd3, SUB);
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("t2_gnt%0d", k), {62'd0, req_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
      tick();
      check_rsp($sformatf("t2_rsp%0d", k), (k % 2 == 0) ? 64'd2 : 64'd7,
                1'(k % 2), 1'b0);
    end

    // requester 0 still waiting; it completes, then backpressure with req1 pending
    set_req(1, 1'b0, 64'd0, 64'd0, ADD);
    #1 check("t3_ready0", {62'd0, req_ready}, 64'd1);
    tick();
    check_rsp("t3_first", 64'd2, 1'b0, 1'b0);
    set_req(0, 1'b0, 64'd0, 64'd0, ADD);
    set_req(1, 1'b1, 64'h00F0, 64'h00FF, XOR);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("t3_bp_ready%0d", k), {62'd0, req_ready}, 64'd0);
      tick();
      check_rsp($sformatf("t3_bp%0d", k), 64'd2, 1'b0, 1'b0);
    end
    rsp_ready = 1'b1;
    #1 check("t3_release", {62'd0, req_ready}, 64'd2);
    tick();
    check_rsp("t3_after", 64'h000F, 1'b1, 1'b0);

    // word ops and a signed compare
    set_req(1, 1'b0, 64'd0, 64'd0, ADD);
    set_req(0, 1'b1, 64'd0, 64'd1, SUBW);
    tick();
    check_rsp("t4_subw", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    set_req(0, 1'b0, 64'd0, 64'd0, ADD);
    set_req(1, 1'b1, 64'h0000_0000_8000_0000, 64'd0, SRLW);
    tick();
    check_rsp("t4_srlw", 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0);
    set_req(1, 1'b0, 64'd0, 64'd0, ADD);
    set_req(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, SLT);
    tick();
    check_rsp("t4_slt", 64'd1, 1'b0, 1'b0);

    // reset with a pending response and rr_ptr at 1
    set_req(0, 1'b0, 64'd0, 64'd0, ADD);
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("t6_rst_valid", {63'd0, rsp_valid}, 64'd0);
    check("t6_rst_data", rsp_data, 64'd0);
    set_req(0, 1'b1, 64'd1, 64'd2, ADD);
    set_req(1, 1'b1, 64'd5, 64'd5, ADD);
    rsp_ready = 1'b1;
    #2 rst_n = 1'b1;
    #1 check("t6_ready", {62'd0, req_ready}, 64'd1);
    tick();
    check_rsp("t6_first", 64'd3, 1'b0, 1'b0);
    set_req(0, 1'b0, 64'd0, 64'd0, ADD);
    #1 check("t6_ready1", {62'd0, req_ready}, 64'd2);
    tick();
    check_rsp("t6_second", 64'd10, 1'b1, 1'b0);
    set_req(1, 1'b0, 64'd0, 64'd0, ADD);
    tick();
    check("t6_drain", {63'd0, rsp_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
